// File: rtl/light_timer_if.sv
// Bus between the light controller (master) and light_timer (slave), plus the
// timer's FSM state exported for debug.
interface light_timer_if #(
  parameter int LIGHT_STATE_WIDTH = 3,
  parameter int CNT_WIDTH         = 8
);
  // No valid/ready pairs on this bus: en and light_cnt_init are levels sampled
  // on every rising clk edge, cfg_wr is a single-cycle write strobe qualifying
  // cfg_sel/cfg_data, and cfg_err, last_cnt and tick are one-cycle pulses that
  // the master must observe in the cycle they are high (no back-pressure).
  logic                         en;
  logic [LIGHT_STATE_WIDTH-1:0] light_cnt_init;
  logic                         cfg_wr;
  logic [1:0]                   cfg_sel;
  logic [CNT_WIDTH-1:0]         cfg_data;
  logic                         cfg_err;
  logic                         last_cnt;
  logic [CNT_WIDTH-1:0]         cnt_value;
  logic                         tick;
  logic [1:0]                   state;

  modport master (
    output en, light_cnt_init, cfg_wr, cfg_sel, cfg_data,
    input  cfg_err, last_cnt, cnt_value, tick, state
  );

  modport slave (
    input  en, light_cnt_init, cfg_wr, cfg_sel, cfg_data,
    output cfg_err, last_cnt, cnt_value, tick, state
  );
endinterface

// File: rtl/light_timer.sv
// Per-light interval timer: prescaled countdown of the active light's duration,
// end-of-interval pulse, and run-time reconfigurable green/yellow/red durations.
module light_timer #(
  parameter int LIGHT_STATE_WIDTH = 3,
  parameter int CNT_WIDTH         = 8,
  parameter int TICK_DIV          = 50000000,
  parameter int GREEN_TIME        = 30,
  parameter int YELLOW_TIME       = 3,
  parameter int RED_TIME          = 27
) (
  input logic          clk,
  input logic          rst,
  light_timer_if.slave bus
);
  localparam int PW = $clog2(TICK_DIV);
  localparam logic [PW-1:0]                PRESC_LAST = PW'(TICK_DIV - 1);
  localparam logic [PW-1:0]                PRESC_ONE  = PW'(1);
  localparam logic [CNT_WIDTH-1:0]         CNT_ONE    = CNT_WIDTH'(1);
  localparam logic [LIGHT_STATE_WIDTH-1:0] INIT_G     = LIGHT_STATE_WIDTH'(1);
  localparam logic [LIGHT_STATE_WIDTH-1:0] INIT_Y     = LIGHT_STATE_WIDTH'(2);
  localparam logic [LIGHT_STATE_WIDTH-1:0] INIT_R     = LIGHT_STATE_WIDTH'(4);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RUN    = 2'd1,
    EXPIRE = 2'd2,
    HOLD   = 2'd3
  } state_t;

  state_t               state;
  logic [PW-1:0]        presc;
  logic [CNT_WIDTH-1:0] cnt;
  logic [CNT_WIDTH-1:0] dur_g;
  logic [CNT_WIDTH-1:0] dur_y;
  logic [CNT_WIDTH-1:0] dur_r;
  logic                 cfg_err_q;

  logic                 init_ok;
  logic [CNT_WIDTH-1:0] init_dur;
  logic                 tick_now;
  logic                 cfg_bad;

  // Only an exact one-hot request selects a duration; anything else is ignored.
  always_comb begin
    init_ok  = 1'b0;
    init_dur = '0;
    if (bus.light_cnt_init == INIT_G) begin
      init_ok  = 1'b1;
      init_dur = dur_g;
    end else if (bus.light_cnt_init == INIT_Y) begin
      init_ok  = 1'b1;
      init_dur = dur_y;
    end else if (bus.light_cnt_init == INIT_R) begin
      init_ok  = 1'b1;
      init_dur = dur_r;
    end
  end

  assign tick_now = (state == RUN) && (presc == PRESC_LAST);
  assign cfg_bad  = bus.cfg_wr && ((bus.cfg_sel == 2'd3) || (bus.cfg_data == '0));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      cnt   <= '0;
      presc <= '0;
    end else if (!bus.en) begin
      state <= IDLE;
      cnt   <= '0;
      presc <= '0;
    end else begin
      case (state)
        IDLE: begin
          cnt   <= dur_g;
          presc <= '0;
          state <= RUN;
        end
        RUN: begin
          if (init_ok) begin
            cnt   <= init_dur;
            presc <= '0;
          end else if (tick_now) begin
            presc <= '0;
            // Saturate at zero; the final tick ends the interval.
            if (cnt <= CNT_ONE) begin
              cnt   <= '0;
              state <= EXPIRE;
            end else begin
              cnt <= cnt - CNT_ONE;
            end
          end else begin
            presc <= presc + PRESC_ONE;
          end
        end
        EXPIRE, HOLD: begin
          if (init_ok) begin
            cnt   <= init_dur;
            presc <= '0;
            state <= RUN;
          end else begin
            state <= HOLD;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Durations change only here; a running countdown keeps its own copy in cnt.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dur_g     <= CNT_WIDTH'(GREEN_TIME);
      dur_y     <= CNT_WIDTH'(YELLOW_TIME);
      dur_r     <= CNT_WIDTH'(RED_TIME);
      cfg_err_q <= 1'b0;
    end else begin
      cfg_err_q <= cfg_bad;
      if (bus.cfg_wr && !cfg_bad) begin
        case (bus.cfg_sel)
          2'd0:    dur_g <= bus.cfg_data;
          2'd1:    dur_y <= bus.cfg_data;
          2'd2:    dur_r <= bus.cfg_data;
          default: ;
        endcase
      end
    end
  end

  assign bus.cfg_err   = cfg_err_q;
  assign bus.last_cnt  = (state == EXPIRE);
  assign bus.cnt_value = cnt;
  assign bus.tick      = tick_now;
  assign bus.state     = state;
endmodule

// File: tb/tb_light_timer.sv
// Bench for light_timer with an attached light-controller model, an interval
// reference model and scoreboards for last_cnt and cfg_err pulses.
module tb_light_timer;
  localparam int LSW = 3;
  localparam int CW  = 8;
  localparam int TD  = 4;
  localparam int G   = 3;
  localparam int Y   = 2;
  localparam int R   = 2;
  localparam int IDLE_S = 0;
  localparam int RUN_S  = 1;
  localparam int EXP_S  = 2;
  localparam int HOLD_S = 3;

  logic clk;
  logic rst;

  light_timer_if #(.LIGHT_STATE_WIDTH(LSW), .CNT_WIDTH(CW)) ifc ();

  light_timer #(
    .LIGHT_STATE_WIDTH(LSW),
    .CNT_WIDTH        (CW),
    .TICK_DIV         (TD),
    .GREEN_TIME       (G),
    .YELLOW_TIME      (Y),
    .RED_TIME         (R)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(ifc)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: the current light interval is described by its loaded
  // duration and the edge it was loaded on; everything else is arithmetic.
  int  edge_no = 0;
  int  mon_cyc = 0;
  int  m_mode;
  int  m_n;
  int  m_load;
  int  m_dur[3];
  bit  m_err;
  logic [31:0] exp_q[$];
  logic [31:0] err_q[$];

  int ctl_light;
  bit auto_ctl;

  task automatic chk(input string name, input int act, input int req);
    n_checks++;
    if (act != req) begin
      n_fail++;
      $display("FAIL %s at cycle %0d: got %0d, required %0d", name, mon_cyc, act, req);
    end
  endtask

  function automatic int exp_cnt();
    if (m_mode == RUN_S) return m_n - (edge_no - m_load) / TD;
    return 0;
  endfunction

  function automatic int exp_tick();
    return int'((m_mode == RUN_S) && (((edge_no - m_load) % TD) == TD - 1));
  endfunction

  function automatic int init_idx(input logic [LSW-1:0] v);
    if (v == 3'b001) return 0;
    if (v == 3'b010) return 1;
    if (v == 3'b100) return 2;
    return -1;
  endfunction

  task automatic model_reset();
    m_mode = IDLE_S;
    m_n    = 0;
    m_load = 0;
    m_dur  = '{G, Y, R};
    m_err  = 1'b0;
    exp_q.delete();
    err_q.delete();
  endtask

  task automatic do_load(input int d);
    m_n    = d;
    m_load = edge_no;
    m_mode = RUN_S;
    exp_q.delete();
    exp_q.push_back(32'(edge_no + d * TD));
  endtask

  // Predicts the effect of the coming rising edge from the inputs now applied.
  task automatic model_edge();
    int li;
    int k;
    edge_no++;
    if (rst) return;
    li = init_idx(ifc.light_cnt_init);
    k  = edge_no - m_load;
    if (!ifc.en) begin
      m_mode = IDLE_S;
      exp_q.delete();
    end else if (m_mode == IDLE_S) begin
      do_load(m_dur[0]);
    end else if (li >= 0) begin
      do_load(m_dur[li]);
    end else if (m_mode == RUN_S && k == m_n * TD) begin
      m_mode = EXP_S;
    end else if (m_mode == EXP_S) begin
      m_mode = HOLD_S;
    end
    m_err = ifc.cfg_wr && (ifc.cfg_sel == 2'd3 || ifc.cfg_data == '0);
    if (m_err) err_q.push_back(32'(edge_no));
    else if (ifc.cfg_wr) m_dur[int'(ifc.cfg_sel)] = int'(ifc.cfg_data);
  endtask

  // Driver: one call per clock; runs from negedge to the next negedge.
  task automatic step();
    if (!ifc.en || rst) ctl_light = 0;
    if (auto_ctl) begin
      if (ifc.last_cnt) begin
        ctl_light = (ctl_light + 1) % 3;
        ifc.light_cnt_init = LSW'(1 << ctl_light);
      end else begin
        ifc.light_cnt_init = '0;
      end
    end
    model_edge();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic wait_run(input int light, input int cnt, input int budget, input string name);
    bit hit;
    hit = 1'b0;
    for (int i = 0; i < budget; i++) begin
      hit = (int'(ifc.state) == RUN_S) && (int'(ifc.cnt_value) == cnt) &&
            (light < 0 || ctl_light == light);
      if (hit) break;
      step();
    end
    chk(name, int'(hit), 1);
  endtask

  task automatic run_until_expire(input int budget, input string name);
    for (int i = 0; i < budget; i++) begin
      if (ifc.last_cnt) break;
      step();
    end
    chk(name, int'(ifc.last_cnt), 1);
  endtask

  task automatic cfg_write(input int sel, input int data);
    ifc.cfg_wr   = 1'b1;
    ifc.cfg_sel  = 2'(sel);
    ifc.cfg_data = CW'(data);
    step();
    ifc.cfg_wr   = 1'b0;
  endtask

  // Monitor / scoreboard
  initial begin
    logic [31:0] t;
    forever begin
      @(posedge clk);
      mon_cyc++;
      #2;
      chk("state", int'(ifc.state), m_mode);
      chk("cnt_value", int'(ifc.cnt_value), exp_cnt());
      chk("tick", int'(ifc.tick), exp_tick());
      chk("last_cnt", int'(ifc.last_cnt), int'(m_mode == EXP_S));
      chk("cfg_err", int'(ifc.cfg_err), int'(m_err));
      if (ifc.last_cnt) begin
        chk("last_cnt_expected", int'(exp_q.size() > 0), 1);
        if (exp_q.size() > 0) begin
          t = exp_q.pop_front();
          chk("last_cnt_time", mon_cyc, int'(t));
        end
      end else if (exp_q.size() > 0 && mon_cyc > int'(exp_q[0])) begin
        chk("last_cnt_missing", mon_cyc, int'(exp_q[0]));
        void'(exp_q.pop_front());
      end
      if (ifc.cfg_err) begin
        chk("cfg_err_expected", int'(err_q.size() > 0), 1);
        if (err_q.size() > 0) begin
          t = err_q.pop_front();
          chk("cfg_err_time", mon_cyc, int'(t));
        end
      end else if (err_q.size() > 0 && mon_cyc > int'(err_q[0])) begin
        chk("cfg_err_missing", mon_cyc, int'(err_q[0]));
        void'(err_q.pop_front());
      end
    end
  end

  // Stimulus
  initial begin
    rst = 1'b1;
    ifc.en = 1'b0;
    ifc.light_cnt_init = '0;
    ifc.cfg_wr = 1'b0;
    ifc.cfg_sel = '0;
    ifc.cfg_data = '0;
    auto_ctl = 1'b1;
    ctl_light = 0;
    model_reset();
    repeat (3) step();

    // Free-running light cycle from reset defaults.
    rst = 1'b0;
    ifc.en = 1'b1;
    repeat (2 * 31 + 5) step();

    // Mid-green yellow rewrite; green finishes unchanged, yellow loads 5.
    wait_run(0, 2, 40, "wait_green_mid");
    cfg_write(1, 5);
    run_until_expire(60, "green_end_after_cfg");
    // Write coinciding with the yellow load: the load keeps the old value 5.
    cfg_write(1, 3);
    repeat (25) step();
    cfg_write(0, 0);
    step();
    cfg_write(3, 9);
    repeat (3) step();
    cfg_write(1, 2);
    repeat (40) step();

    // Enable drop mid-run.
    wait_run(-1, 2, 60, "wait_cnt2_for_en");
    ifc.en = 1'b0;
    step();
    chk("en_drop_cnt", int'(ifc.cnt_value), 0);
    chk("en_drop_state", int'(ifc.state), IDLE_S);
    ifc.en = 1'b1;
    step();
    chk("en_reload_green", int'(ifc.cnt_value), G);
    repeat (20) step();

    // Asynchronous reset mid-yellow, after moving yellow away from default.
    cfg_write(1, 4);
    wait_run(1, 4, 80, "wait_yellow");
    repeat (2) step();
    #1 rst = 1'b1;
    model_reset();
    ctl_light = 0;
    #1;
    chk("rst_async_cnt", int'(ifc.cnt_value), 0);
    chk("rst_async_state", int'(ifc.state), IDLE_S);
    chk("rst_async_last", int'(ifc.last_cnt), 0);
    chk("rst_async_tick", int'(ifc.tick), 0);
    step();
    step();
    rst = 1'b0;
    repeat (35) step();

    // Non-one-hot init ignored, one-hot red init reloads immediately.
    wait_run(0, 3, 80, "wait_green_load");
    auto_ctl = 1'b0;
    ifc.light_cnt_init = 3'b011;
    step();
    ifc.light_cnt_init = 3'b100;
    step();
    chk("force_red_cnt", int'(ifc.cnt_value), R);
    ifc.light_cnt_init = '0;
    ctl_light = 2;
    auto_ctl = 1'b1;
    repeat (12) step();

    // Withheld init parks the timer in HOLD.
    auto_ctl = 1'b0;
    ifc.light_cnt_init = '0;
    run_until_expire(80, "hold_expire");
    repeat (5) step();
    chk("hold_state", int'(ifc.state), HOLD_S);
    ifc.light_cnt_init = 3'b001;
    step();
    chk("hold_reload_green", int'(ifc.cnt_value), G);
    ifc.light_cnt_init = '0;
    ctl_light = 0;
    auto_ctl = 1'b1;
    repeat (20) step();

    // Randomized traffic: enable drops, config writes, stray init values.
    repeat (400) begin
      ifc.en = ($urandom_range(0, 49) != 0);
      if ($urandom_range(0, 14) == 0) begin
        ifc.cfg_wr   = 1'b1;
        ifc.cfg_sel  = 2'($urandom_range(0, 3));
        ifc.cfg_data = CW'($urandom_range(0, 4));
      end else begin
        ifc.cfg_wr = 1'b0;
      end
      if ($urandom_range(0, 19) == 0) begin
        auto_ctl = 1'b0;
        ifc.light_cnt_init = LSW'($urandom_range(0, 7));
      end else begin
        auto_ctl = 1'b1;
      end
      step();
    end
    ifc.cfg_wr = 1'b0;
    ifc.en = 1'b1;
    auto_ctl = 1'b1;
    repeat (5) step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/light_timer.md
LIGHT_TIMER -- requirements
Module: light_timer

Interface
REQ-001 Parameters (one per line: name, default, meaning):
- LIGHT_STATE_WIDTH, 3, width of one-hot light vectors; bit 0 green, bit 1 yellow, bit 2 red.
- CNT_WIDTH, 8, width of the countdown and duration registers.
- TICK_DIV, 50000000, clk cycles per count tick (>=2).
- GREEN_TIME, 30, reset duration for green, in ticks (>=1).
- YELLOW_TIME, 3, reset duration for yellow, in ticks (>=1).
- RED_TIME, 27, reset duration for red, in ticks (>=1).
REQ-002 Ports (one per line: name, direction, width, meaning):
- clk, in, 1, single clock, all state on rising edge.
- rst, in, 1, reset; asynchronous, active-high.
- en, in, 1, block enable; same signal that drives the light controller.
- light_cnt_init, in, LIGHT_STATE_WIDTH, one-hot load request from the light controller.
- cfg_wr, in, 1, single-cycle duration write strobe.
- cfg_sel, in, 2, duration select: 0 green, 1 yellow, 2 red, 3 invalid.
- cfg_data, in, CNT_WIDTH, new duration in ticks.
- cfg_err, out, 1, one-cycle pulse when a cfg_wr is rejected.
- last_cnt, out, 1, one-cycle pulse marking the end of the current light interval.
- cnt_value, out, CNT_WIDTH, remaining ticks, for display.
- tick, out, 1, one-cycle prescaler pulse, for debug.

Function
REQ-003 The block SHALL implement states IDLE, RUN, EXPIRE and HOLD.
REQ-004 Duration registers dur_g, dur_y and dur_r SHALL reset to GREEN_TIME, YELLOW_TIME and RED_TIME.
REQ-005 cfg_wr with cfg_sel<3 and cfg_data!=0 SHALL update the selected duration register at that edge.
REQ-006 cfg_wr with cfg_sel==3 or cfg_data==0 SHALL leave all duration registers unchanged and SHALL pulse cfg_err on the next cycle.
REQ-007 A configuration write SHALL take effect only at the next load and SHALL NOT alter a countdown already in progress.
REQ-008 IDLE with en==1 SHALL load dur_g, clear the prescaler and enter RUN; the controller issues no init on its own IDLE->GREEN step.
REQ-009 In RUN, the prescaler SHALL count 0..TICK_DIV-1 and pulse tick when it equals TICK_DIV-1, then wrap to 0.
REQ-010 Each tick in RUN SHALL decrement cnt_value; the tick that reaches 0 SHALL move the block to EXPIRE.
REQ-011 last_cnt SHALL equal 1 if and only if the state is EXPIRE, giving exactly one cycle of assertion.
REQ-012 The cycle of last_cnt SHALL occur exactly N*TICK_DIV clk edges after the load edge, where N is the loaded duration.
REQ-013 In EXPIRE or HOLD, a one-hot light_cnt_init SHALL load the matching duration register, clear the prescaler and enter RUN; cnt_value SHALL show the new value on the next cycle.
REQ-014 EXPIRE without a valid init SHALL go to HOLD, with cnt_value 0 and last_cnt 0, and wait there for an init.
REQ-015 A one-hot init received during RUN SHALL reload immediately and restart the prescaler.
REQ-016 A light_cnt_init that is not one-hot (two or more bits set) SHALL be ignored in every state.
REQ-017 en==0 SHALL synchronously force IDLE, cnt_value=0 and prescaler=0 on the next edge; en==0 SHALL override any init or tick in the same cycle.
REQ-018 If cfg_wr and a load occur in the same cycle, the load SHALL use the old register value.
REQ-019 cnt_value SHALL never wrap below 0.

Reset
REQ-020 While rst is high, the block SHALL be in IDLE with cnt_value=0, prescaler=0, last_cnt=0, tick=0, cfg_err=0, and durations at their parameter defaults.
REQ-021 Reset SHALL act immediately, mid-countdown included, with no clk edge required.
REQ-022 After rst falls, the first en==1 edge SHALL load green per REQ-008.

Verification
Bench parameters: TICK_DIV=4, GREEN_TIME=3, YELLOW_TIME=2, RED_TIME=2, with the light controller attached.
REQ-023 Release rst, hold en=1 -> cnt_value 3,2,1,0 at 4-cycle spacing; last_cnt pulses 12 edges after load; yellow loads 2; then red loads 2; then green loads 3; the full cycle repeats every 28+3 cycles.
REQ-024 cfg_wr with sel=1, data=5 mid-green -> green completes unchanged and the next yellow loads 5; cfg_wr with data=0 -> cfg_err pulses once and the registers are unchanged.
REQ-025 Drop en mid-RUN at cnt_value=2 -> next cycle IDLE with cnt_value=0; raise en -> green reloads 3.
REQ-026 Assert rst asynchronously mid-yellow -> outputs clear immediately; durations return to 3/2/2.
REQ-027 Force init=3'b011 in RUN -> ignored; force init=3'b100 in RUN -> cnt_value=2 next cycle and the prescaler restarts.
REQ-028 Withhold init at EXPIRE -> HOLD with cnt_value 0 and a single last_cnt pulse; later init=3'b001 -> RUN with cnt_value 3.
